// File: rtl/wb_burst_gen_pkg.sv
// Shared definitions for the Wishbone burst generator.
//   state_t     : controller FSM states
//   MODE_*      : operation select encodings on the mode input
//   CTI_*       : Wishbone cycle-type identifiers driven on wb_cti_o
//   lfsr_taps() : Galois feedback mask (maximal length) for a data width
package wb_burst_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    WR,
    RD,
    DONE
  } state_t;

  localparam logic [1:0] MODE_WR       = 2'b00;
  localparam logic [1:0] MODE_RD       = 2'b01;
  localparam logic [1:0] MODE_WRRB     = 2'b10;
  localparam logic [1:0] MODE_WRRB_ALT = 2'b11;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Right-shifting Galois masks: x^8+x^6+x^5+x^4+1, x^16+x^14+x^13+x^11+1,
  // x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_taps(input int dw);
    case (dw)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/wb_burst_gen_lfsr.sv
// Galois LFSR that produces the write pattern / readback reference.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset (q -> 0)
//   load, seed         : reload from seed (a zero seed becomes all ones)
//   advance            : step one position
//   q                  : current LFSR value
module wb_lfsr #(
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          load,
  input  logic [DW-1:0] seed,
  input  logic          advance,
  output logic [DW-1:0] q
);
  import wb_burst_gen_pkg::*;

  localparam logic [31:0]   TAPS_ALL = lfsr_taps(DW);
  localparam logic [DW-1:0] TAPS     = TAPS_ALL[DW-1:0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      q <= '0;
    end else if (load) begin
      // all-zero is the lock-up state of the register
      q <= (seed == '0) ? '1 : seed;
    end else if (advance) begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/wb_burst_gen.sv
// Wishbone burst master: writes an LFSR pattern, reads it back, or both,
// and counts readback mismatches. Guards every beat with an ack watchdog.
//   wb_clk_i, wb_rst_i     : clock, synchronous active-high reset
//   start, mode            : launch pulse, 00 wr / 01 rd / 1x wr+readback
//   base_addr, burst_len   : start byte address, beats per phase
//   seed                   : LFSR seed for each phase
//   init_done              : SDRAM controller ready
//   busy, done             : activity flag, one-cycle completion pulse
//   err_cnt, timeout       : saturating mismatch count, sticky ack timeout
//   wb_*                   : Wishbone master (incrementing bursts)
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_INIT | request latched, waiting for init_done
// WR        | write burst (gap_q: one idle bus cycle after the last ack)
// RD        | read burst  (gap_q: one idle bus cycle after the last ack)
// DONE      | done pulse, back to IDLE
module wb_burst_gen #(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int BLW    = 8,
  parameter int TO_CYC = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   base_addr,
  input  logic [BLW-1:0]  burst_len,
  input  logic [DW-1:0]   seed,
  input  logic            init_done,
  output logic            busy,
  output logic            done,
  output logic [15:0]     err_cnt,
  output logic            timeout,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i
);
  import wb_burst_gen_pkg::*;

  localparam int              WDW       = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [WDW-1:0]  WD_LOAD   = WDW'(TO_CYC - 1);
  localparam logic [AW-1:0]   ADDR_STEP = AW'(DW / 8);

  state_t         state, state_nxt;
  logic [1:0]     mode_q;
  logic [AW-1:0]  base_q;
  logic [BLW-1:0] len_q;
  logic [DW-1:0]  seed_q;
  logic [BLW-1:0] rem_q, rem_nxt;
  logic [WDW-1:0] wd_q;
  logic           gap_q, gap_nxt;
  logic           accept, beat, last_beat, wd_tc, rb_mode, phase_start;
  logic           cyc_nxt, we_nxt, busy_nxt, done_nxt;
  logic [2:0]     cti_nxt;

  assign accept    = (state == IDLE) && start;
  assign beat      = wb_cyc_o && wb_ack_i;
  assign last_beat = beat && (rem_q == BLW'(1));
  // an ack on the terminal cycle still completes the beat
  assign wd_tc     = wb_stb_o && !wb_ack_i && (wd_q == '0);
  assign rb_mode   = mode_q[1];

  // state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    gap_nxt   = 1'b0;
    case (state)
      IDLE:      if (start) state_nxt = WAIT_INIT;
      WAIT_INIT: begin
        if (len_q == '0)    state_nxt = DONE;
        else if (init_done) state_nxt = (mode_q == MODE_RD) ? RD : WR;
      end
      WR, RD: begin
        if (gap_q)          state_nxt = (state == WR && rb_mode) ? RD : DONE;
        else if (wd_tc)     state_nxt = DONE;
        else if (last_beat) gap_nxt   = 1'b1;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign phase_start = (state_nxt == WR || state_nxt == RD) && (state == WAIT_INIT || gap_q);

  always_comb begin
    rem_nxt = rem_q;
    if (phase_start) rem_nxt = len_q;
    else if (beat)   rem_nxt = rem_q - 1'b1;
  end

  // outputs, computed one cycle ahead so that every port is a flop
  always_comb begin
    cyc_nxt  = (state_nxt == WR || state_nxt == RD) && !gap_nxt;
    we_nxt   = cyc_nxt && (state_nxt == WR);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    cti_nxt  = CTI_CLASSIC;
    if (cyc_nxt) cti_nxt = (rem_nxt == BLW'(1)) ? CTI_EOB : CTI_INCR;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_cti_o <= CTI_CLASSIC;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wb_cyc_o <= cyc_nxt;
      wb_stb_o <= cyc_nxt;
      wb_we_o  <= we_nxt;
      wb_sel_o <= cyc_nxt ? '1 : '0;
      wb_cti_o <= cti_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mode_q    <= MODE_WR;
      base_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      rem_q     <= '0;
      wd_q      <= WD_LOAD;
      gap_q     <= 1'b0;
      wb_addr_o <= '0;
      err_cnt   <= '0;
      timeout   <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= (mode == MODE_WRRB_ALT) ? MODE_WRRB : mode;
        base_q  <= base_addr;
        len_q   <= burst_len;
        seed_q  <= seed;
        err_cnt <= '0;
        timeout <= 1'b0;
      end
      rem_q <= rem_nxt;
      gap_q <= gap_nxt;

      if (phase_start)  wb_addr_o <= base_q;
      else if (beat)    wb_addr_o <= wb_addr_o + ADDR_STEP;

      // watchdog is a down-counter; terminal count at zero
      if (phase_start || beat)        wd_q <= WD_LOAD;
      else if (wb_stb_o && wd_q != '0) wd_q <= wd_q - 1'b1;

      if (wd_tc) timeout <= 1'b1;

      if (beat && state == RD && rb_mode && wb_dat_i != wb_dat_o && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  wb_lfsr #(.DW(DW)) u_lfsr (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (phase_start),
    .seed     (seed_q),
    .advance  (beat),
    .q        (wb_dat_o)
  );

endmodule
